// File: rtl/signed_adder_8b_if.sv
`default_nettype none
// ============================================================================
// Module   : signed_adder_8b_if
// Purpose  : Operand/result bundle for the registered signed adder.
//            master drives operands and carry-in and observes results;
//            slave (the adder) consumes operands and drives the results.
// Signals  : firstcin - carry into bit 0
//            A, B     - WIDTH-bit two's-complement operands
//            S        - registered WIDTH-bit sum
//            v        - registered signed-overflow flag
//            lastcout - registered carry out of the MSB
// Revision : 1.0 - initial release
// ============================================================================
interface signed_adder_8b_if #(
  parameter int WIDTH = 8
);
  logic             firstcin;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] S;
  logic             v;
  logic             lastcout;

  modport master (
    output firstcin, A, B,
    input  S, v, lastcout
  );

  modport slave (
    input  firstcin, A, B,
    output S, v, lastcout
  );
endinterface
`default_nettype wire

// File: rtl/signed_adder_8b.sv
`default_nettype none
// ============================================================================
// Module   : signed_adder_8b
// Purpose  : Registered WIDTH-bit two's-complement adder, A + B + firstcin,
//            built as a ripple chain of full-adder cells. Sum, carry-out and
//            signed overflow are captured in an output register (1-cycle
//            latency, a new operation accepted every cycle).
// Ports    : clk - rising-edge clock
//            rst - synchronous active-high reset (clears S, v, lastcout)
//            bus - signed_adder_8b_if.slave (firstcin, A, B in; S, v,
//                  lastcout out)
// Options  : SIGNED_ADDER_SAT_EN - when defined, S saturates to the most
//            positive/negative value on signed overflow; v and lastcout
//            still report the raw result.
// Revision : 1.0 - initial release
// ============================================================================
module signed_adder_8b #(
  parameter int WIDTH = 8
) (
  input  wire logic          clk,
  input  wire logic          rst,
  signed_adder_8b_if.slave   bus
);

  localparam logic [WIDTH-1:0] C_SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] C_SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0]   w_c;      // w_c[i] is the carry into cell i
  logic [WIDTH-1:0] w_s;
  logic             w_v;
  logic [WIDTH-1:0] w_s_next;

  logic [WIDTH-1:0] r_s;
  logic             r_v;
  logic             r_cout;

  // Ripple-carry chain of full-adder cells.
  always_comb begin
    w_c    = '0;
    w_s    = '0;
    w_c[0] = bus.firstcin;
    for (int i = 0; i < WIDTH; i++) begin
      w_s[i]   = bus.A[i] ^ bus.B[i] ^ w_c[i];
      w_c[i+1] = (bus.A[i] & bus.B[i]) | (w_c[i] & (bus.A[i] ^ bus.B[i]));
    end
  end

  // Signed overflow: carry into the sign cell disagrees with carry out of it.
  assign w_v = w_c[WIDTH] ^ w_c[WIDTH-1];

`ifdef SIGNED_ADDER_SAT_EN
  // Overflow only happens with same-sign operands, so A's sign alone picks
  // the direction of saturation.
  always_comb begin
    w_s_next = w_s;
    if (w_v) begin
      w_s_next = bus.A[WIDTH-1] ? C_SAT_NEG : C_SAT_POS;
    end
  end
`else
  assign w_s_next = w_s;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s    <= '0;
      r_v    <= 1'b0;
      r_cout <= 1'b0;
    end else begin
      r_s    <= w_s_next;
      r_v    <= w_v;
      r_cout <= w_c[WIDTH];
    end
  end

  assign bus.S        = r_s;
  assign bus.v        = r_v;
  assign bus.lastcout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_signed_adder_8b.sv
`default_nettype none
// ============================================================================
// Module   : tb_signed_adder_8b
// Purpose  : Self-checking bench for signed_adder_8b (WIDTH = 8). Directed
//            vectors from the adder's documented behaviour plus a randomized
//            back-to-back stream with one reset pulse, checked against an
//            integer-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_signed_adder_8b;

  localparam int WIDTH = 8;

  logic clk;
  logic rst;

  signed_adder_8b_if #(.WIDTH(WIDTH)) bus ();

  signed_adder_8b #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       cin;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s_wrap;
    logic [7:0] s_sat;
    logic       v;
    logic       co;
  } vec_t;

  // Reference model: true integer result, then reduce to the adder's view.
  // Returns {S, v, lastcout}.
  function automatic logic [9:0] golden(input logic [7:0] a, input logic [7:0] b,
                                        input logic cin);
    int         u;
    int         sg;
    logic [7:0] s;
    logic       v;
    logic       co;
    u  = int'(a) + int'(b) + int'(cin);
    sg = int'($signed(a)) + int'($signed(b)) + int'(cin);
    s  = u[7:0];
    co = (u >= 256);
    v  = (sg > 127) || (sg < -128);
`ifdef SIGNED_ADDER_SAT_EN
    if (v) s = (sg > 127) ? 8'h7F : 8'h80;
`endif
    return {s, v, co};
  endfunction

  task automatic drive(input logic cin, input logic [7:0] a, input logic [7:0] b);
    bus.firstcin = cin;
    bus.A        = a;
    bus.B        = b;
  endtask

  task automatic test_reset();
    logic [9:0] exp;
    rst = 1'b1;
    drive(1'b0, 8'h55, 8'h55);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({bus.S, bus.v, bus.lastcout} !== 10'b0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got S=%02h v=%b co=%b, want S=00 v=0 co=0",
                 k, bus.S, bus.v, bus.lastcout);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
`ifdef SIGNED_ADDER_SAT_EN
    exp = {8'h7F, 1'b1, 1'b0};
`else
    exp = {8'hAA, 1'b1, 1'b0};
`endif
    n_checks++;
    if ({bus.S, bus.v, bus.lastcout} !== exp) begin
      n_fail++;
      $display("FAIL reset_release: got S=%02h v=%b co=%b, want S=%02h v=%b co=%b",
               bus.S, bus.v, bus.lastcout, exp[9:2], exp[1], exp[0]);
    end
  endtask

  task automatic test_directed();
    vec_t       t[10];
    logic [7:0] exp_s;
    t[0] = '{1'b0, 8'd15,  8'd26,  8'd41,  8'd41,  1'b0, 1'b0};
    t[1] = '{1'b0, 8'd99,  8'd45,  8'h90,  8'h7F,  1'b1, 1'b0};
    t[2] = '{1'b0, 8'd127, 8'd127, 8'hFE,  8'h7F,  1'b1, 1'b0};
    t[3] = '{1'b0, 8'hD3,  8'hAD,  8'h80,  8'h80,  1'b0, 1'b1}; // -45 + -83
    t[4] = '{1'b0, 8'h87,  8'hF8,  8'h7F,  8'h80,  1'b1, 1'b1}; // -121 + -8
    t[5] = '{1'b0, 8'hC0,  8'hC0,  8'h80,  8'h80,  1'b0, 1'b1}; // -64 + -64
    t[6] = '{1'b0, 8'h80,  8'h80,  8'h00,  8'h80,  1'b1, 1'b1}; // -128 + -128
    t[7] = '{1'b1, 8'h81,  8'h7F,  8'h01,  8'h01,  1'b0, 1'b1}; // -127 + 127 + 1
    t[8] = '{1'b0, 8'h0F,  8'hF1,  8'h00,  8'h00,  1'b0, 1'b1}; // 15 + -15
    t[9] = '{1'b1, 8'h22,  8'hD3,  8'hF6,  8'hF6,  1'b0, 1'b0}; // 34 + -45 + 1
    for (int i = 0; i < 10; i++) begin
      drive(t[i].cin, t[i].a, t[i].b);
      @(posedge clk); #1;
`ifdef SIGNED_ADDER_SAT_EN
      exp_s = t[i].s_sat;
`else
      exp_s = t[i].s_wrap;
`endif
      n_checks++;
      if ({bus.S, bus.v, bus.lastcout} !== {exp_s, t[i].v, t[i].co}) begin
        n_fail++;
        $display("FAIL directed[%0d] A=%02h B=%02h cin=%b: got S=%02h v=%b co=%b, want S=%02h v=%b co=%b",
                 i, t[i].a, t[i].b, t[i].cin, bus.S, bus.v, bus.lastcout,
                 exp_s, t[i].v, t[i].co);
      end
    end
  endtask

  task automatic test_back_to_back();
    int         rst_at;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [9:0] exp;
    rst_at = $urandom_range(20, 80);
    for (int i = 0; i < 100; i++) begin
      a   = 8'($urandom);
      b   = 8'($urandom);
      cin = 1'($urandom);
      rst = (i == rst_at);
      drive(cin, a, b);
      exp = rst ? 10'b0 : golden(a, b, cin);
      @(posedge clk); #1;
      n_checks++;
      if ({bus.S, bus.v, bus.lastcout} !== exp) begin
        n_fail++;
        $display("FAIL b2b[%0d] rst=%b A=%02h B=%02h cin=%b: got S=%02h v=%b co=%b, want S=%02h v=%b co=%b",
                 i, rst, a, b, cin, bus.S, bus.v, bus.lastcout, exp[9:2], exp[1], exp[0]);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 8'h00, 8'h00);
    test_reset();
    test_directed();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
